// File: rtl/alu_word_seq_65ce02_pkg.sv
// Shared definitions for the 16-bit word sequencer in front of the 8-bit 65CE02 ALU.
// Holds the word-op codes, the ALU op encodings the sequencer drives, the FSM state
// encoding and the carry-in source selector used between decoder and top.
package alu_word_seq_65ce02_pkg;

  // Word op codes on wop
  localparam logic [2:0] WopInw  = 3'b000;
  localparam logic [2:0] WopDew  = 3'b001;
  localparam logic [2:0] WopAsw  = 3'b010;
  localparam logic [2:0] WopRow  = 3'b011;
  localparam logic [2:0] WopLsrw = 3'b100;
  localparam logic [2:0] WopRorw = 3'b101;
  localparam logic [2:0] WopAsrw = 3'b110;
  localparam logic [2:0] WopRsvd = 3'b111;

  // ALU op encodings
  localparam logic [3:0] AluAdd  = 4'b0011;
  localparam logic [3:0] AluSub  = 4'b0111;
  localparam logic [3:0] AluDbl  = 4'b1011;
  localparam logic [3:0] AluPass = 4'b1111;

  // Sequencer states
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StP1   = 2'd1;
  localparam logic [1:0] StP2   = 2'd2;
  localparam logic [1:0] StCap  = 2'd3;

  // Where the ALU carry-in comes from on a given pass
  typedef enum logic [2:0] {
    CiZero,
    CiOne,
    CiCin,
    CiSign,
    CiCarry
  } ci_sel_e;

endpackage

// File: rtl/alu_word_seq_65ce02_decode.sv
// Combinational decode of a word op and pass index into the ALU control set.
// Ports:
//   wop      - latched word op
//   pass2    - 0 for the first byte pass, 1 for the second
//   op       - ALU op code
//   right    - ALU right-shift select
//   arith    - ALU arithmetic-shift select
//   bi       - ALU BI byte
//   ci_sel   - carry-in source for this pass
//   hi_first - high byte goes through the ALU first (right shifts)
//   keep_c   - C flag is left unchanged by this op
module alu_word_seq_65ce02_decode
  import alu_word_seq_65ce02_pkg::*;
(
  input  logic [2:0] wop,
  input  logic       pass2,
  output logic [3:0] op,
  output logic       right,
  output logic       arith,
  output logic [7:0] bi,
  output ci_sel_e    ci_sel,
  output logic       hi_first,
  output logic       keep_c
);

  always_comb begin
    op       = AluPass;
    right    = 1'b0;
    arith    = 1'b0;
    bi       = 8'h00;
    // Second pass always chains the carry/shift-out of the first pass
    ci_sel   = pass2 ? CiCarry : CiZero;
    hi_first = 1'b0;
    keep_c   = 1'b0;
    case (wop)
      WopInw: begin
        op     = AluAdd;
        keep_c = 1'b1;
        if (!pass2) ci_sel = CiOne;
      end
      WopDew: begin
        // AI + ~01 + 1 = AI - 1; the high pass adds ~00 plus the no-borrow carry
        op     = AluSub;
        keep_c = 1'b1;
        bi     = pass2 ? 8'h00 : 8'h01;
        if (!pass2) ci_sel = CiOne;
      end
      WopAsw: begin
        op = AluDbl;
      end
      WopRow: begin
        op = AluDbl;
        if (!pass2) ci_sel = CiCin;
      end
      WopLsrw: begin
        right    = 1'b1;
        hi_first = 1'b1;
      end
      WopRorw: begin
        right    = 1'b1;
        hi_first = 1'b1;
        if (!pass2) ci_sel = CiCin;
      end
      WopAsrw: begin
        // Sign bit also offered on CI so the first pass shifts it in either way
        right    = 1'b1;
        arith    = 1'b1;
        hi_first = 1'b1;
        if (!pass2) ci_sel = CiSign;
      end
      default: begin
        // Reserved: plain pass-through, C unchanged
        keep_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_word_seq_65ce02.sv
// Word-op sequencer for the 8-bit 65CE02 ALU. Runs INW/DEW/ASW/ROW/LSRW/RORW/ASRW as
// two byte passes through the registered ALU and returns a 16-bit result with N/Z/C.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   rdy               - global ready, freezes all state when low
//   start, wop        - request and word op, sampled in IDLE
//   operand, c_in     - word operand and current C, latched on accept
//   busy, done        - in-flight indicator and one-cycle completion pulse
//   result, c/n/z_out - word result and flags, held until the next done
//   alu_*  (out)      - ALU drive: ai, bi, ci, op, right, arith, bcd
//   alu_out, alu_co   - registered ALU result and carry-out
module alu_word_seq_65ce02
  import alu_word_seq_65ce02_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic        start,
  input  logic [2:0]  wop,
  input  logic [15:0] operand,
  input  logic        c_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        c_out,
  output logic        n_out,
  output logic        z_out,
  output logic [7:0]  alu_ai,
  output logic [7:0]  alu_bi,
  output logic        alu_ci,
  output logic [3:0]  alu_op,
  output logic        alu_right,
  output logic        alu_arith,
  output logic        alu_bcd,
  input  logic [7:0]  alu_out,
  input  logic        alu_co
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  wop_q, wop_d;
  logic [15:0] opnd_q, opnd_d;
  logic        cin_q, cin_d;
  logic [7:0]  byte0_q, byte0_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic        c_q, c_d;
  logic        z_q, z_d;

  logic [3:0] dec_op;
  logic       dec_right;
  logic       dec_arith;
  logic [7:0] dec_bi;
  ci_sel_e    dec_ci_sel;
  logic       dec_hi_first;
  logic       dec_keep_c;
  logic       active;
  logic       pass2;

  assign active = (state_q == StP1) || (state_q == StP2);
  assign pass2  = (state_q == StP2);

  alu_word_seq_65ce02_decode u_decode (
    .wop      (wop_q),
    .pass2    (pass2),
    .op       (dec_op),
    .right    (dec_right),
    .arith    (dec_arith),
    .bi       (dec_bi),
    .ci_sel   (dec_ci_sel),
    .hi_first (dec_hi_first),
    .keep_c   (dec_keep_c)
  );

  // ALU drive; idle values outside the two presenting states
  always_comb begin
    alu_ai    = 8'h00;
    alu_bi    = 8'h00;
    alu_ci    = 1'b0;
    alu_op    = AluPass;
    alu_right = 1'b0;
    alu_arith = 1'b0;
    if (active) begin
      // First pass takes the leading byte, second pass the other one
      if (pass2 ^ dec_hi_first) alu_ai = opnd_q[15:8];
      else                      alu_ai = opnd_q[7:0];
      alu_bi    = dec_bi;
      alu_op    = dec_op;
      alu_right = dec_right;
      alu_arith = dec_arith;
      case (dec_ci_sel)
        CiOne:   alu_ci = 1'b1;
        CiCin:   alu_ci = cin_q;
        CiSign:  alu_ci = opnd_q[15];
        CiCarry: alu_ci = alu_co;
        default: alu_ci = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    wop_d    = wop_q;
    opnd_d   = opnd_q;
    cin_d    = cin_q;
    byte0_d  = byte0_q;
    done_d   = done_q;
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    if (rdy) begin
      case (state_q)
        StIdle: begin
          done_d = 1'b0;
          if (start) begin
            wop_d   = wop;
            opnd_d  = operand;
            cin_d   = c_in;
            state_d = StP1;
          end
        end
        StP1: state_d = StP2;
        StP2: begin
          // ALU output now holds the first-pass byte
          byte0_d = alu_out;
          state_d = StCap;
        end
        default: begin
          if (dec_hi_first) result_d = {byte0_q, alu_out};
          else              result_d = {alu_out, byte0_q};
          c_d     = dec_keep_c ? cin_q : alu_co;
          z_d     = (result_d == 16'h0000);
          done_d  = 1'b1;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      wop_q    <= 3'b000;
      opnd_q   <= 16'h0000;
      cin_q    <= 1'b0;
      byte0_q  <= 8'h00;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      wop_q    <= wop_d;
      opnd_q   <= opnd_d;
      cin_q    <= cin_d;
      byte0_q  <= byte0_d;
      done_q   <= done_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign result  = result_q;
  assign c_out   = c_q;
  assign n_out   = result_q[15];
  assign z_out   = z_q;
  assign alu_bcd = 1'b0;

endmodule

// File: tb/tb_alu_word_seq_65ce02.sv
// Bench for alu_word_seq_65ce02 with a behavioural registered 8-bit ALU beside it.
module tb_alu_word_seq_65ce02;

  logic        clk;
  logic        reset;
  logic        rdy;
  logic        start;
  logic [2:0]  wop;
  logic [15:0] operand;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        c_out;
  logic        n_out;
  logic        z_out;
  logic [7:0]  alu_ai;
  logic [7:0]  alu_bi;
  logic        alu_ci;
  logic [3:0]  alu_op;
  logic        alu_right;
  logic        alu_arith;
  logic        alu_bcd;
  logic [7:0]  alu_out;
  logic        alu_co;

  int n_chk;
  int n_bad;

  alu_word_seq_65ce02 dut (
    .clk       (clk),
    .reset     (reset),
    .rdy       (rdy),
    .start     (start),
    .wop       (wop),
    .operand   (operand),
    .c_in      (c_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .c_out     (c_out),
    .n_out     (n_out),
    .z_out     (z_out),
    .alu_ai    (alu_ai),
    .alu_bi    (alu_bi),
    .alu_ci    (alu_ci),
    .alu_op    (alu_op),
    .alu_right (alu_right),
    .alu_arith (alu_arith),
    .alu_bcd   (alu_bcd),
    .alu_out   (alu_out),
    .alu_co    (alu_co)
  );

  // Behavioural 65CE02-style ALU: op[1:0] picks the logic term (OR/AND/XOR/AI),
  // op[3:2] picks the adder's second input (BI/~BI/logic/0); RDY-qualified register.
  logic [7:0] m_logic;
  logic [7:0] m_b;
  logic [8:0] m_sum;
  logic [7:0] m_nxt;
  logic       m_nco;

  always_comb begin
    m_logic = alu_ai;
    m_b     = 8'h00;
    case (alu_op[1:0])
      2'b00:   m_logic = alu_ai | alu_bi;
      2'b01:   m_logic = alu_ai & alu_bi;
      2'b10:   m_logic = alu_ai ^ alu_bi;
      default: m_logic = alu_ai;
    endcase
    case (alu_op[3:2])
      2'b00:   m_b = alu_bi;
      2'b01:   m_b = ~alu_bi;
      2'b10:   m_b = m_logic;
      default: m_b = 8'h00;
    endcase
    m_sum = {1'b0, m_logic} + {1'b0, m_b} + {8'h00, alu_ci};
    if (alu_right) begin
      m_nxt = {(alu_arith ? alu_ai[7] : alu_ci), m_logic[7:1]};
      m_nco = m_logic[0];
    end else begin
      m_nxt = m_sum[7:0];
      m_nco = m_sum[8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_out <= 8'h00;
      alu_co  <= 1'b0;
    end else if (rdy) begin
      alu_out <= m_nxt;
      alu_co  <= m_nco;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op at the current negedge and watch it for lat+2 cycles.
  task automatic run_op(input string tag, input logic [2:0] w, input logic [15:0] opnd,
                        input logic ci, input logic [15:0] er, input logic ec,
                        input int lat, input bit stall, input bit hold);
    int first;
    int cnt;
    first   = 0;
    cnt     = 0;
    wop     = w;
    operand = opnd;
    c_in    = ci;
    start   = 1'b1;
    for (int cyc = 1; cyc <= lat + 2; cyc++) begin
      @(negedge clk);
      if (!hold || cyc >= lat - 1) start = 1'b0;
      if (stall && cyc == 2) rdy = 1'b0;
      if (stall && cyc == 5) rdy = 1'b1;
      if (cyc == 1) check_val({tag, " busy"}, 32'(busy), 32'd1);
      if (done) begin
        cnt++;
        if (first == 0) begin
          first = cyc;
          check_val({tag, " result"}, 32'(result), 32'(er));
          check_val({tag, " c"}, 32'(c_out), 32'(ec));
          check_val({tag, " n"}, 32'(n_out), 32'(er[15]));
          check_val({tag, " z"}, 32'(z_out), 32'(er == 16'h0000));
        end
      end
    end
    check_val({tag, " latency"}, 32'(first), 32'(lat));
    check_val({tag, " done count"}, 32'(cnt), 32'd1);
    check_val({tag, " held"}, 32'(result), 32'(er));
    check_val({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_chk   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    rdy     = 1'b1;
    start   = 1'b0;
    wop     = 3'b000;
    operand = 16'h0000;
    c_in    = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst busy", 32'(busy), 32'd0);
    check_val("rst done", 32'(done), 32'd0);
    check_val("rst result", 32'(result), 32'd0);
    check_val("rst flags", {29'd0, c_out, n_out, z_out}, 32'd0);
    check_val("rst alu_op", 32'(alu_op), 32'hF);
    check_val("rst alu_ai", 32'(alu_ai), 32'd0);
    check_val("rst alu_misc", {27'd0, alu_bi == 8'h00, alu_ci, alu_right, alu_arith, alu_bcd},
              32'd16);
    reset = 1'b0;
    @(negedge clk);

    run_op("inw00ff", 3'b000, 16'h00FF, 1'b0, 16'h0100, 1'b0, 4, 1'b0, 1'b0);
    run_op("inwffff", 3'b000, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 4, 1'b0, 1'b0);
    run_op("dew0000", 3'b001, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 4, 1'b0, 1'b0);
    run_op("dew0100", 3'b001, 16'h0100, 1'b0, 16'h00FF, 1'b0, 4, 1'b0, 1'b0);
    run_op("asw8001", 3'b010, 16'h8001, 1'b0, 16'h0002, 1'b1, 4, 1'b0, 1'b0);
    run_op("row4000", 3'b011, 16'h4000, 1'b1, 16'h8001, 1'b0, 4, 1'b0, 1'b0);
    run_op("lsrw0101", 3'b100, 16'h0101, 1'b0, 16'h0080, 1'b1, 4, 1'b0, 1'b0);
    run_op("asrw8002", 3'b110, 16'h8002, 1'b0, 16'hC001, 1'b0, 4, 1'b0, 1'b0);
    run_op("rorw0001", 3'b101, 16'h0001, 1'b1, 16'h8000, 1'b1, 4, 1'b0, 1'b0);
    run_op("rsvd", 3'b111, 16'hA5C3, 1'b1, 16'hA5C3, 1'b1, 4, 1'b0, 1'b0);

    // Reset in P2 of an ASW: aborted op must never signal done
    wop     = 3'b010;
    operand = 16'h1111;
    c_in    = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("pre-rst alu_op", 32'(alu_op), 32'hB);
    reset = 1'b1;
    #1;
    check_val("mid-rst busy", 32'(busy), 32'd0);
    check_val("mid-rst done", 32'(done), 32'd0);
    check_val("mid-rst result", 32'(result), 32'd0);
    check_val("mid-rst flags", {29'd0, c_out, n_out, z_out}, 32'd0);
    check_val("mid-rst alu_op", 32'(alu_op), 32'hF);
    check_val("mid-rst alu_ai", 32'(alu_ai), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_op("inw1234", 3'b000, 16'h1234, 1'b0, 16'h1235, 1'b0, 4, 1'b0, 1'b0);

    // rdy low for three cycles in P2, start held while busy
    run_op("row8000", 3'b011, 16'h8000, 1'b0, 16'h0000, 1'b1, 7, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_word_seq_65ce02.md
Name: alu_word_seq_65ce02

Overview:
Upstream sequencer for the 8-bit 65CE02 ALU that executes 16-bit word operations in two byte passes: INW, DEW, ASW, ROW, plus word right shifts.
- Drives the ALU's op, AI, BI, CI, right and arith inputs.
- Consumes the registered OUT and CO, chaining CO into the second pass.
- Returns a 16-bit result with N/Z/C flags to the core's execute stage.

Parameters:
none (fixed 16-bit word; ALU result latency fixed at one RDY-qualified cycle)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rdy  in  1  global ready; same signal as the ALU RDY; 0 freezes all state
start  in  1  request; sampled only in IDLE with rdy=1
wop  in  3  word op: 000 INW, 001 DEW, 010 ASW, 011 ROW, 100 LSRW, 101 RORW, 110 ASRW, 111 reserved
operand  in  16  word operand, latched on accepted start
c_in  in  1  current C flag, latched on accepted start
busy  out  1  high from accept+1 until done
done  out  1  one-cycle pulse; result and flags valid while high
result  out  16  word result; holds its value until the next done
c_out  out  1  resulting C
n_out  out  1  result[15]
z_out  out  1  result==16'h0000
alu_ai  out  8  to ALU AI
alu_bi  out  8  to ALU BI
alu_ci  out  1  to ALU CI
alu_op  out  4  to ALU op
alu_right  out  1  to ALU right
alu_arith  out  1  to ALU arith
alu_bcd  out  1  to ALU BCD; tied 0
alu_out  in  8  from ALU OUT (registered)
alu_co  in  1  from ALU CO (registered)

Behaviour:
- States: IDLE, P1 (first byte presented), P2 (second byte presented, first result captured), CAP (second result captured).
- Transitions, each taken only when rdy=1: IDLE -start-> P1 -> P2 -> CAP -> IDLE. With rdy=0 every register holds, including done.
- Timing, start sampled at cycle N with rdy continuously high: busy=1 in cycles N+1..N+3; done=1 in cycle N+4 together with result and flags.
- start is ignored while busy=1.
- Byte order:
  - Left ops (000-011): low byte in P1, high byte in P2.
  - Right ops (100-110): high byte in P1, low byte in P2.
- Pass 1 ALU drive:
  - INW: op=0011, BI=00, CI=1.
  - DEW: op=0111, BI=01, CI=1.
  - ASW: op=1011, CI=0.
  - ROW: op=1011, CI=c_in.
  - LSRW: right=1, arith=0, op=1111, CI=0.
  - RORW: right=1, arith=0, op=1111, CI=c_in.
  - ASRW: right=1, arith=1, op=1111.
- Pass 2 ALU drive: same op, right and arith as pass 1; AI = other byte; BI=00 for INW and DEW; CI = alu_co captured from pass 1.
- Flags:
  - c_out = final alu_co for ASW, ROW, LSRW, RORW, ASRW.
  - c_out = latched c_in for INW and DEW (C unchanged).
  - n_out = result[15]; z_out = (result==0) for all ops.
- Reserved wop=111: runs the full sequence with op=1111 and right=0 (pass-through); result=operand, c_out=c_in.
- ALU drive values in IDLE and CAP: ai=0, bi=0, ci=0, op=1111, right=0, arith=0.
- Reset value of every output: 0, except alu_op=4'b1111. Internal state resets to IDLE.
- Reset mid-operation: immediate return to IDLE; no done pulse for the aborted op; a start in the first cycle after reset release is accepted.
- Arithmetic wraps modulo 2^16 (FFFF+1 -> 0000; 0000-1 -> FFFF).

Decomposition:
- Shared package: wop codes; ALU op constants (ADD 4'b0011, SUB 4'b0111, DBL 4'b1011, PASS 4'b1111); state encoding.
- Optional sub-module word_op_decode: combinational map from wop and pass index to {op, right, arith, bi, ci source, byte order}.
- The FSM and capture registers stay in the top module.
- The bench instantiates the real 65CE02 ALU beside the sequencer.

Test Plan:
1. INW operand=00FF, c_in=0 -> result=0100, n=0, z=0, c_out=0, done exactly at N+4; then INW FFFF -> 0000, z=1.
2. DEW 0000, c_in=1 -> FFFF, n=1, z=0, c_out=1; DEW 0100 -> 00FF.
3. ASW 8001 -> 0002, c_out=1; ROW 4000, c_in=1 -> 8001, c_out=0, n=1.
4. LSRW 0101 -> 0080, c_out=1; ASRW 8002 -> C001, c_out=0; RORW 0001, c_in=1 -> 8000, c_out=1, n=1.
5. ROW 8000, c_in=0 with rdy low for 3 cycles during P2 -> done at N+7, result=0000, c=1, z=1; a start asserted while busy is ignored (exactly one done).
6. reset pulsed in P2 of an ASW -> busy=0, done never fires, all outputs 0 and alu_op=1111; next INW 1234 -> 1235.
